xor_top: RTL and testbench
==========================

// Module: xor_top
// PURPOSE
//  Synthesizable behavioural model of a K-way XOR arbiter PUF (physically unclonable function).
//  - Each of K arbiter chains turns an N-bit challenge into a 1-bit decision.
//  - The chains use the additive-delay model with per-instance delay weights fixed at elaboration.
//  - The chain decisions are XORed and the result is registered as the response.
//  - Sits behind a challenge driver; used for PUF-protocol and modelling experiments.
// PARAMETERS
//  N     128      challenge width = switch stages per chain (N >= 1)
//  K     4        number of parallel arbiter chains XORed together (K >= 1)
//  W     8        signed bit width of each stage delay-difference weight
//  SEED  16'hACE1 instance seed for the weights; different SEED = different "chip"
// PORTS
//  clk    in   1  single clock, rising edge
//  reset  in   1  asynchronous, active-high reset
//  in     in   1  launch strobe; an evaluation happens on each rising clk edge where in=1
//  sel    in   N  challenge; sel[i] sets the straight/cross state of switch stage i
//  out    out  1  registered PUF response
// BEHAVIOUR
//  Reset:
//  - reset=1 forces out=0 immediately, independent of clk, and out holds 0 while reset=1.
//  - Weights are constants and are not affected by reset.
//  Weights:
//  - Chain c, with 0 <= c < K, has N+1 signed W-bit weights w[c][0..N].
//  - Generator: 16-bit Galois LFSR with mask 16'hB400, start state SEED ^ (16'h1111*(c+1)).
//  - An all-zero start state is replaced by 16'h0001.
//  - Step the LFSR once per weight. After step j+1, w[c][j] = low W bits of the state, read as two's complement.
//  Features:
//  - phi_i = XOR of sel[N-1:i], for i = 0..N-1.
//  - Feature term t_i = +w[c][i] when phi_i=0, and -w[c][i] when phi_i=1.
//  Chain decision:
//  - D_c = sum of t_i over i = 0..N-1, plus w[c][N] (bias).
//  - The sum is computed in full precision: SW = W + clog2(N+2) bits, so it never overflows.
//  - r_c = 1 when D_c >= 0; r_c = 0 when D_c < 0. A tie (D_c == 0) gives 1.
//  Response:
//  - On a rising clk edge with in=1 and reset=0: out <= r_0 ^ r_1 ^ ... ^ r_{K-1}, computed from sel at that edge.
//  - Latency is 1 cycle: out is valid after the same edge that samples in=1.
//  - in=0 at an edge: out holds its previous value.
//  - in held high: the response is re-evaluated every cycle.
//  - sel changes between edges have no effect until the next edge with in=1.
//  - Reset deasserted mid-stream: the first edge with in=1 after release produces a fresh response. No warm-up cycles are needed.
//  Determinism and data path:
//  - The same (SEED, N, K, W, sel) always gives the same out. No internal state besides the out flop.
//  - The data path is purely combinational from sel to the out flop. No X is permitted on out after reset.
// STRUCTURE
//  Package xor_puf_pkg holds:
//  - the LFSR mask constant and the weight-generator function lfsr_weight(seed, chain, idx);
//  - the sum-width function sum_w(N, W).
//  Sub-module arbiter_chain #(N, W, SEED, CHAIN_ID):
//  - inputs sel[N-1:0], output r (combinational);
//  - builds the weight ROM at elaboration, plus the parity-prefix and signed adder tree.
//  xor_top:
//  - generate loop of K arbiter_chain instances;
//  - XOR-reduce of their r outputs;
//  - one async-reset response flop.
// TESTING
//  1. Reset: assert reset with in=1 and sel=random -> out=0 immediately; out stays 0 for 5 edges while reset is held.
//  2. Hold: reset=0, in=1, sel=32'hDEADBEEF for one edge, then in=0 with sel random for 10 edges -> out keeps the value captured at the first edge.
//  3. Golden model: 100 pairs of random (in, sel), sel = zero-extended 32-bit random values, 10-cycle spacing.
//     - A bench model built on the lfsr_weight function predicts out.
//     - Required: out matches the model 1 cycle after every edge with in=1.
//  4. Repeatability: apply sel=128'h0, then 128'h1, then 128'h0 again, each with in=1 -> the first and third responses are identical.
//  5. K=1 corner: N=4, W=8, SEED=16'h0001. Sweep all 16 challenges.
//     - Required: out equals sign(D_0) computed by hand from the 5 generated weights.
//  6. Uniqueness: two instances with SEED=16'hACE1 and SEED=16'h1234 each get the same 1000 random challenges.
//     - Required: the responses differ on between 30% and 70% of the challenges.

Source files
------------

// File: rtl/xor_puf_pkg.sv
// Shared constants and elaboration-time helpers for the XOR arbiter PUF.
// Weight generation is a pure function of (seed, chain, idx) so RTL and models agree.
package xor_puf_pkg;

   localparam logic [15:0] LFSR_MASK = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
   endfunction

   // Returns the LFSR state after idx+1 steps; callers keep the low W bits as the weight.
   function automatic logic [15:0] lfsr_weight(input logic [15:0] seed, input int chain,
                                               input int idx);
      logic [15:0] st;
      st = seed ^ 16'(16'h1111 * (chain + 1));
      if (st == 16'h0000)
         st = 16'h0001;
      for (int k = 0; k <= idx; k++)
         st = lfsr_step(st);
      return st;
   endfunction

   function automatic int sum_w(input int n, input int w);
      return w + $clog2(n + 2);
   endfunction

endpackage

// File: rtl/arbiter_chain.sv
// One additive-delay arbiter chain: combinational sel -> r, no state, no backpressure.
// Weights are elaboration constants; r is the sign of the summed delay difference.
module arbiter_chain
   import xor_puf_pkg::*;
#(
   parameter int          N        = 128,
   parameter int          W        = 8,
   parameter logic [15:0] SEED     = 16'hACE1,
   parameter int          CHAIN_ID = 0
) (
   input  logic [N-1:0] sel,
   output logic         r
);

   localparam int SW = sum_w(N, W);
   localparam logic signed [SW-1:0] ZERO = '0;

   logic [N-1:0]          phi;
   logic signed [SW-1:0]  term [N+1];
   logic signed [SW-1:0]  acc;

   // phi[i] is the parity of the challenge from stage i to the output end.
   assign phi[N-1] = sel[N-1];
   for (genvar i = 0; i < N - 1; i++) begin : g_phi
      assign phi[i] = sel[i] ^ phi[i+1];
   end

   for (genvar i = 0; i <= N; i++) begin : g_w
      localparam logic [15:0]          ST = lfsr_weight(SEED, CHAIN_ID, i);
      localparam logic signed [W-1:0]  WT = ST[W-1:0];
      localparam logic signed [SW-1:0] WX = WT;
      if (i < N) begin : g_stage
         assign term[i] = phi[i] ? -WX : WX;
      end else begin : g_bias
         assign term[i] = WX;
      end
   end

   // Full-precision sum; synthesis is free to rebalance this into a tree.
   always_comb begin
      acc = '0;
      for (int j = 0; j <= N; j++)
         acc = acc + term[j];
   end

   assign r = (acc >= ZERO);

endmodule

// File: rtl/xor_top.sv
// K-way XOR arbiter PUF: out registers the XOR of K chain decisions, 1-cycle latency.
// No backpressure; an edge with in=1 re-evaluates, in=0 holds out.
module xor_top
   import xor_puf_pkg::*;
#(
   parameter int          N    = 128,
   parameter int          K    = 4,
   parameter int          W    = 8,
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in,
   input  logic [N-1:0] sel,
   output logic         out
);

   logic [K-1:0] r;

   for (genvar c = 0; c < K; c++) begin : g_chain
      arbiter_chain #(
         .N        (N),
         .W        (W),
         .SEED     (SEED),
         .CHAIN_ID (c)
      ) u_chain (
         .sel (sel),
         .r   (r[c])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         out <= 1'b0;
      else if (in)
         out <= ^r;
   end

endmodule

// File: tb/tb_xor_top.sv
// Scoreboard bench for xor_top: driver queues expected responses, monitor checks each launch edge.
module tb_xor_top;
   import xor_puf_pkg::*;

   typedef struct {
      logic  chk0;
      logic  exp0;
      logic  chk2;
      logic  exp2;
      string name;
   } exp_t;

   logic         clk;
   logic         reset;
   logic         in;
   logic [127:0] sel;
   logic         out0, out1, out2;

   int   tests = 0;
   int   fails = 0;
   exp_t sbq[$];
   int   wa[4][129];

   xor_top #(.N(128), .K(4), .W(8), .SEED(16'hACE1)) u0 (
      .clk(clk), .reset(reset), .in(in), .sel(sel), .out(out0));
   xor_top #(.N(128), .K(4), .W(8), .SEED(16'h1234)) u1 (
      .clk(clk), .reset(reset), .in(in), .sel(sel), .out(out1));
   xor_top #(.N(4), .K(1), .W(8), .SEED(16'h0001)) u2 (
      .clk(clk), .reset(reset), .in(in), .sel(sel[3:0]), .out(out2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Additive-delay model of the SEED=ACE1 instance, walking stages from the output end.
   function automatic logic model0(input logic [127:0] s);
      logic res;
      logic ph;
      int   d;
      res = 1'b0;
      for (int c = 0; c < 4; c++) begin
         d  = wa[c][128];
         ph = 1'b0;
         for (int i = 127; i >= 0; i--) begin
            ph = ph ^ s[i];
            d  = ph ? d - wa[c][i] : d + wa[c][i];
         end
         res = res ^ (d >= 0);
      end
      return res;
   endfunction

   task automatic step(input logic i, input logic [127:0] s, input string nm,
                       input logic c2, input logic e2);
      exp_t e;
      @(negedge clk);
      in  = i;
      sel = s;
      if (i) begin
         e.chk0 = 1'b1;
         e.exp0 = model0(s);
         e.chk2 = c2;
         e.exp2 = e2;
         e.name = nm;
         sbq.push_back(e);
      end
   endtask

   // Monitor: every edge that sampled in=1 outside reset presents a fresh response.
   initial begin
      logic launch;
      exp_t e;
      forever begin
         @(posedge clk);
         launch = in && !reset;
         #1;
         if (launch) begin
            if (sbq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_underflow: got response expected none");
            end else begin
               e = sbq.pop_front();
               if (e.chk0) chk(e.name, out0, e.exp0);
               if (e.chk2) chk({e.name, "_k1"}, out2, e.exp2);
            end
         end
      end
   end

   initial begin
      logic [15:0]      st;
      logic signed [7:0] b;
      logic             h;
      logic [15:0]      exp5;
      logic [127:0]     s1;
      int               diff;
      int               found;

      for (int c = 0; c < 4; c++)
         for (int j = 0; j <= 128; j++) begin
            st       = lfsr_weight(16'hACE1, c, j);
            b        = st[7:0];
            wa[c][j] = b;
         end

      // 1. asynchronous reset, held with in=1
      reset = 1'b0;
      in    = 1'b0;
      sel   = '0;
      #2;
      reset = 1'b1;
      in    = 1'b1;
      sel   = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk("rst_imm0", out0, 1'b0);
      chk("rst_imm2", out2, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk("rst_hold", out0, 1'b0);
      end
      @(negedge clk);
      in    = 1'b0;
      reset = 1'b0;

      // 2. hold when in=0
      step(1'b1, 128'hDEADBEEF, "hold_cap", 1'b0, 1'b0);
      h = model0(128'hDEADBEEF);
      for (int k = 0; k < 10; k++) begin
         step(1'b0, {96'h0, $urandom}, "", 1'b0, 1'b0);
         @(posedge clk);
         #2;
         chk("hold", out0, h);
      end

      // 3. golden model, random launches with 10-cycle spacing
      for (int k = 0; k < 100; k++) begin
         step(1'($urandom_range(0, 1)), {96'h0, $urandom}, "golden", 1'b0, 1'b0);
         for (int m = 0; m < 9; m++)
            step(1'b0, {96'h0, $urandom}, "", 1'b0, 1'b0);
      end

      // 4. repeatability
      step(1'b1, 128'h0, "rep_a", 1'b0, 1'b0);
      step(1'b1, 128'h1, "rep_b", 1'b0, 1'b0);
      step(1'b1, 128'h0, "rep_c", 1'b0, 1'b0);
      step(1'b0, 128'h0, "", 1'b0, 1'b0);

      // mid-stream async reset from out=1, then a fresh response after release
      found = -1;
      for (int v = 0; v < 256 && found < 0; v++)
         if (model0(128'(v)) == 1'b1) found = v;
      if (found >= 0) begin
         s1 = 128'(found);
         step(1'b1, s1, "pre_rst", 1'b0, 1'b0);
         @(posedge clk);
         #3;
         reset = 1'b1;
         #1;
         chk("rst_async", out0, 1'b0);
         @(negedge clk);
         in = 1'b0;
         @(negedge clk);
         reset = 1'b0;
         step(1'b1, s1, "post_rst", 1'b0, 1'b0);
         step(1'b0, s1, "", 1'b0, 1'b0);
      end

      // 5. K=1, N=4 corner: weights -120,68,34,17, bias -120 -> r=1 for sel 1,7,11,13
      exp5 = 16'h2882;
      for (int c = 0; c < 16; c++)
         step(1'b1, 128'(c), "k1sweep", 1'b1, exp5[c]);
      step(1'b0, 128'h0, "", 1'b0, 1'b0);

      // 6. uniqueness between two seeds, in held high
      diff = 0;
      for (int k = 0; k < 1000; k++) begin
         step(1'b1, {$urandom, $urandom, $urandom, $urandom}, "uniq", 1'b0, 1'b0);
         @(posedge clk);
         #2;
         if (out0 !== out1) diff++;
      end
      step(1'b0, 128'h0, "", 1'b0, 1'b0);
      tests++;
      if (diff < 300 || diff > 700) begin
         fails++;
         $display("FAIL uniqueness: got %0d differing of 1000 expected 300..700", diff);
      end

      repeat (5) @(posedge clk);
      #2;
      if (sbq.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL sb_drain: got %0d pending expected 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
